// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifq_pkg;

  typedef enum logic [1:0] {
    REDIRECT = 2'd0,
    FETCH    = 2'd1,
    FULL     = 2'd2
  } ifq_state_e;

  localparam int unsigned IFQ_DEPTH    = 4;
  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Fetch-queue storage: DEPTH entries, extra-MSB pointers for full/empty, flash clear.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  ifq_entry_t               wdata_i,
  output ifq_entry_t               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  ifq_entry_t      mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic            do_push, do_pop;

  always_comb begin
    wr_idx  = wr_ptr_q[AW-1:0];
    rd_idx  = rd_ptr_q[AW-1:0];
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    count_o = wr_ptr_q - rd_ptr_q;
    rdata_o = empty_o ? '0 : mem_q[rd_idx];
    do_push = push_i && !clear_i;
    do_pop  = pop_i && !clear_i;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_idx] <= wdata_i;
  end

  // Credit-based fetching upstream makes these unreachable in a correct design.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i) begin
      assert (!(push_i && full_o && !pop_i));
      assert (!(pop_i && empty_o));
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: fetch FSM, credit control and redirect handling.
// Optional empty-queue bypass of cache responses is enabled by macro IFQ_BYPASS_EN.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = IFQ_DEPTH,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] Ifq_icache_addr,
  output logic        Ifq_icache_ren,
  input  logic [31:0] Icache_data,
  input  logic        Icache_valid,
  output logic [31:0] ifetch_intruction,
  output logic [31:0] ifetch_pc_4,
  output logic        ifetch_empty,
  input  logic        Dispatch_ren,
  input  logic        Dispatch_jmp,
  input  logic [31:0] Dispatch_jmp_addr
);

  localparam int unsigned AW = $clog2(DEPTH);

  ifq_state_e    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          outst_q, outst_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  ifq_entry_t    fifo_wdata, fifo_rdata;

  logic          resp_ok, bypass, head_valid, pop_req, has_credit, ren;
  logic [AW+1:0] credit_used;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (Dispatch_jmp),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    resp_ok = Icache_valid && outst_q && (state_q != REDIRECT) && !Dispatch_jmp;
`ifdef IFQ_BYPASS_EN
    bypass  = resp_ok && fifo_empty;
`else
    bypass  = 1'b0;
`endif
    head_valid = !fifo_empty || bypass;
    pop_req    = Dispatch_ren && head_valid && !Dispatch_jmp;
    fifo_pop   = pop_req && !fifo_empty;
    // A bypassed word consumed this cycle never enters storage.
    fifo_push  = resp_ok && !(bypass && pop_req);
    fifo_wdata = '{instr: Icache_data, pc_4: req_pc_q + 32'd4};

    credit_used = {1'b0, fifo_count} + {{(AW + 1){1'b0}}, outst_q};
    has_credit  = !fifo_full && (credit_used < (AW + 2)'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    unique case (state_q)
      REDIRECT: begin
        ren     = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (has_credit) ren = 1'b1;
        else if (!pop_req) state_d = FULL;
      end
      FULL: begin
        if (pop_req) state_d = FETCH;
      end
      default: state_d = REDIRECT;
    endcase
    if (Dispatch_jmp) begin
      ren     = 1'b0;
      state_d = REDIRECT;
    end

    fetch_pc_d = fetch_pc_q;
    if (Dispatch_jmp) fetch_pc_d = Dispatch_jmp_addr;
    else if (ren)     fetch_pc_d = fetch_pc_q + 32'd4;
    req_pc_d = ren ? fetch_pc_q : req_pc_q;
    outst_d  = ren;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= REDIRECT;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      outst_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      outst_q    <= outst_d;
    end
  end

  always_comb begin
    Ifq_icache_ren  = ren && !reset;
    Ifq_icache_addr = reset ? RESET_PC : fetch_pc_q;
    ifetch_empty    = reset || !head_valid;
    ifetch_intruction = '0;
    ifetch_pc_4       = '0;
    if (!ifetch_empty) begin
      if (bypass) begin
        ifetch_intruction = Icache_data;
        ifetch_pc_4       = req_pc_q + 32'd4;
      end else begin
        ifetch_intruction = fifo_rdata.instr;
        ifetch_pc_4       = fifo_rdata.pc_4;
      end
    end
  end

endmodule
